// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, select fields.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_SLT = 3'b011,
    ALU_LUI = 3'b100
  } aluop_t;

  typedef enum logic [SEL_W-1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_HIGH = 2'b10} extop_t;
  typedef enum logic [SEL_W-1:0] {GPR_RT = 2'b00, GPR_RD = 2'b01} gprsel_t;
  typedef enum logic [SEL_W-1:0] {WD_ALU = 2'b00, WD_DM = 2'b01} wdsel_t;
  typedef enum logic [SEL_W-1:0] {NPC_PC4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10} npcop_t;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_RTYPE, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_ADDI
  } iclass_t;

  // Static datapath selects that depend only on the instruction, not the state.
  typedef struct packed {
    aluop_t  aluop;
    extop_t  extop;
    logic    bsel;
    gprsel_t gprsel;
    wdsel_t  wdsel;
  } sel_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode/funct decode to instruction class and static selects.
// addi is decoded only when CTRL_ADDI_OVF_EN is defined.
module main_decoder
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  output iclass_t         iclass,
  output sel_t            sel
);

  always_comb begin
    iclass = C_ILLEGAL;
    sel    = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = C_RTYPE; sel.aluop = ALU_ADD; sel.gprsel = GPR_RD; end
          FN_SUBU: begin iclass = C_RTYPE; sel.aluop = ALU_SUB; sel.gprsel = GPR_RD; end
          FN_SLT:  begin iclass = C_RTYPE; sel.aluop = ALU_SLT; sel.gprsel = GPR_RD; end
          default: ;
        endcase
      end
      OP_ORI: begin
        iclass = C_ORI; sel.aluop = ALU_OR; sel.extop = EXT_ZERO; sel.bsel = 1'b1;
      end
      OP_LW: begin
        iclass = C_LW; sel.aluop = ALU_ADD; sel.extop = EXT_SIGN; sel.bsel = 1'b1;
        sel.wdsel = WD_DM;
      end
      OP_SW: begin
        iclass = C_SW; sel.aluop = ALU_ADD; sel.extop = EXT_SIGN; sel.bsel = 1'b1;
      end
      OP_BEQ: begin
        iclass = C_BEQ; sel.aluop = ALU_SUB; sel.extop = EXT_SIGN;
      end
      OP_LUI: begin
        iclass = C_LUI; sel.aluop = ALU_LUI; sel.extop = EXT_HIGH; sel.bsel = 1'b1;
      end
      OP_J: iclass = C_J;
`ifdef CTRL_ADDI_OVF_EN
      OP_ADDI: begin
        iclass = C_ADDI; sel.aluop = ALU_ADD; sel.extop = EXT_SIGN; sel.bsel = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM_RD/MEM_WR/WB).
// Define CTRL_ADDI_OVF_EN to add addi with overflow-suppressed register write.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic               dm_ready,
  output logic               pcwr,
  output logic               irwr,
  output logic               gprwr,
  output logic               dmwr,
  output logic               dmrd,
  output logic [ALUOP_W-1:0] aluop,
  output logic [SEL_W-1:0]   extop,
  output logic [SEL_W-1:0]   gprsel,
  output logic [SEL_W-1:0]   wdsel,
  output logic [SEL_W-1:0]   npcop,
  output logic               bsel,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] opcode_q, dec_op;
  logic [FN_W-1:0] funct_q, dec_fn;
  iclass_t         iclass;
  sel_t            sel;
  logic            sel_en;
  logic            ovf_block;

  // DECODE looks at the live IR fields; every later state uses the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;
  assign dec_fn = (state_q == S_DECODE) ? funct  : funct_q;

  main_decoder u_main_decoder (
    .opcode (dec_op),
    .funct  (dec_fn),
    .iclass (iclass),
    .sel    (sel)
  );

`ifdef CTRL_ADDI_OVF_EN
  assign ovf_block = (iclass == C_ADDI) && overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign ovf_block       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
    end
  end

  // Next state and outputs; everything is forced low while rst is high.
  always_comb begin
    state_d = state_q;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    gprwr   = 1'b0;
    dmwr    = 1'b0;
    dmrd    = 1'b0;
    illegal = 1'b0;
    npcop   = SEL_W'(NPC_PC4);
    sel_en  = 1'b0;
    aluop   = '0;
    extop   = '0;
    gprsel  = '0;
    wdsel   = '0;
    bsel    = 1'b0;
    state   = STATE_W'(state_q);
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          irwr    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (iclass == C_J) begin
            pcwr    = 1'b1;
            npcop   = SEL_W'(NPC_JUMP);
            state_d = S_FETCH;
          end else if (iclass == C_ILLEGAL) begin
            illegal = 1'b1;
            pcwr    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          sel_en = 1'b1;
          case (iclass)
            C_BEQ: begin
              pcwr    = 1'b1;
              npcop   = zero ? SEL_W'(NPC_BRANCH) : SEL_W'(NPC_PC4);
              state_d = S_FETCH;
            end
            C_LW:    state_d = S_MEM_RD;
            C_SW:    state_d = S_MEM_WR;
            default: state_d = S_WB;
          endcase
        end
        S_MEM_RD: begin
          sel_en = 1'b1;
          dmrd   = 1'b1;
          if (dm_ready) state_d = S_WB;
        end
        S_MEM_WR: begin
          sel_en = 1'b1;
          dmwr   = 1'b1;
          if (dm_ready) begin
            pcwr    = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          sel_en  = 1'b1;
          gprwr   = !ovf_block;
          pcwr    = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      if (sel_en) begin
        aluop  = ALUOP_W'(sel.aluop);
        extop  = SEL_W'(sel.extop);
        gprsel = SEL_W'(sel.gprsel);
        wdsel  = SEL_W'(sel.wdsel);
        bsel   = sel.bsel;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then randomized instruction stream
// against a per-instruction cycle model. Honours CTRL_ADDI_OVF_EN like the design.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, dm_ready;
  logic       pcwr, irwr, gprwr, dmwr, dmrd, bsel, illegal;
  logic [2:0] aluop, state;
  logic [1:0] extop, gprsel, wdsel, npcop;

  int n_vec = 0;
  int n_err = 0;

  localparam int K_ILL = 0, K_R = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_LUI = 6, K_J = 7, K_ADDI = 8;

  logic [5:0] op_tab [0:9] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b100011,
                               6'b101011, 6'b000100, 6'b001111, 6'b000010, 6'b001000};
  logic [5:0] fn_tab [0:9] = '{6'b100001, 6'b100011, 6'b101010, 6'd0, 6'd0,
                               6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .dm_ready(dm_ready), .pcwr(pcwr), .irwr(irwr),
    .gprwr(gprwr), .dmwr(dmwr), .dmrd(dmrd), .aluop(aluop), .extop(extop),
    .gprsel(gprsel), .wdsel(wdsel), .npcop(npcop), .bsel(bsel),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction class straight from the encoding table.
  function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b101010) ? K_R : K_ILL;
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001111: return K_LUI;
      6'b000010: return K_J;
`ifdef CTRL_ADDI_OVF_EN
      6'b001000: return K_ADDI;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int ref_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b100001) ? 0 : (fn == 6'b100011) ? 1 : 3;
    case (op)
      6'b001101: return 2;
      6'b000100: return 1;
      6'b001111: return 4;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [10:0] ev(input int st, input int pc, input int ir, input int gw,
                                     input int dw, input int dr, input int il, input int np);
    return {3'(st), 1'(pc), 1'(ir), 1'(gw), 1'(dw), 1'(dr), 1'(il), (pc != 0) ? 2'(np) : 2'b00};
  endfunction

  function automatic logic [10:0] obs_strb();
    return {state, pcwr, irwr, gprwr, dmwr, dmrd, illegal, npcop & {2{pcwr}}};
  endfunction

  function automatic logic [9:0] obs_sel();
    return {aluop, extop, bsel, gprsel, wdsel};
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic dmr,
                     input logic z, input logic ov);
    @(negedge clk);
    opcode = op; funct = fn; dm_ready = dmr; zero = z; overflow = ov;
    #1;
  endtask

  // One instruction from FETCH to its final (pcwr) cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                           input logic z, input logic ov);
    int  k;
    int  ext_exp;
    logic last;
    k = ref_class(op, fn);
    cyc(r6(), r6(), rb(), rb(), rb());
    chk("fetch", 32'(obs_strb()), 32'(ev(0, 0, 1, 0, 0, 0, 0, 0)));
    cyc(op, fn, rb(), rb(), rb());
    if (k == K_J) begin
      chk("decode_j", 32'(obs_strb()), 32'(ev(1, 1, 0, 0, 0, 0, 0, 2)));
      return;
    end
    if (k == K_ILL) begin
      chk("decode_illegal", 32'(obs_strb()), 32'(ev(1, 1, 0, 0, 0, 0, 1, 0)));
      return;
    end
    chk("decode", 32'(obs_strb()), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0)));
    // opcode/funct now carry garbage: the controller must use its latched copy
    cyc(r6(), r6(), rb(), z, rb());
    if (k == K_BEQ)
      chk("exec_beq", 32'(obs_strb()), 32'(ev(2, 1, 0, 0, 0, 0, 0, z ? 1 : 0)));
    else
      chk("exec", 32'(obs_strb()), 32'(ev(2, 0, 0, 0, 0, 0, 0, 0)));
    chk("exec_aluop", 32'(aluop), 32'(ref_alu(op, fn)));
    chk("exec_bsel", 32'(bsel), (k == K_R || k == K_BEQ) ? 32'd0 : 32'd1);
    if (k != K_R && k != K_BEQ) begin
      ext_exp = (k == K_ORI) ? 0 : (k == K_LUI) ? 2 : 1;
      chk("exec_extop", 32'(extop), 32'(ext_exp));
    end
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= waits; i++) begin
        last = (i == waits);
        cyc(r6(), r6(), last, rb(), rb());
        if (k == K_LW)
          chk("mem_rd", 32'(obs_strb()), 32'(ev(3, 0, 0, 0, 0, 1, 0, 0)));
        else
          chk("mem_wr", 32'(obs_strb()), 32'(ev(4, last ? 1 : 0, 0, 0, 1, 0, 0, 0)));
      end
      if (k == K_SW) return;
    end
    cyc(r6(), r6(), rb(), rb(), ov);
    chk("wb", 32'(obs_strb()), 32'(ev(5, 1, 0, (k == K_ADDI && ov) ? 0 : 1, 0, 0, 0, 0)));
    chk("wb_gprsel", 32'(gprsel), (k == K_R) ? 32'd1 : 32'd0);
    chk("wb_wdsel", 32'(wdsel), (k == K_LW) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int sel;
    logic [5:0] op, fn;
    rst = 1'b1;
    opcode = r6(); funct = r6(); zero = rb(); overflow = rb(); dm_ready = rb();

    // Reset: everything low, state FETCH, even across clock edges
    #12;
    chk("reset_strobes", 32'(obs_strb()), 32'd0);
    chk("reset_selects", 32'(obs_sel()), 32'd0);
    @(posedge clk); #1;
    chk("reset_hold", 32'({obs_strb(), obs_sel()}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed instructions
    run_instr(6'b000000, 6'b100001, 0, 1'b0, 1'b1);   // addu
    run_instr(6'b000000, 6'b100011, 0, 1'b0, 1'b0);   // subu
    run_instr(6'b000000, 6'b101010, 0, 1'b0, 1'b0);   // slt
    run_instr(6'b100011, 6'b000000, 3, 1'b0, 1'b0);   // lw, 3 wait cycles
    run_instr(6'b000100, 6'b000000, 0, 1'b1, 1'b0);   // beq taken
    run_instr(6'b000100, 6'b000000, 0, 1'b0, 1'b0);   // beq not taken
    run_instr(6'b000010, 6'b000000, 0, 1'b0, 1'b0);   // j
    run_instr(6'b111111, 6'b000000, 0, 1'b0, 1'b0);   // unsupported
    run_instr(6'b000000, 6'b000000, 0, 1'b0, 1'b0);   // unsupported funct
    run_instr(6'b001101, 6'b000000, 0, 1'b0, 1'b0);   // ori
    run_instr(6'b001111, 6'b000000, 0, 1'b0, 1'b0);   // lui
    run_instr(6'b101011, 6'b000000, 2, 1'b0, 1'b0);   // sw, 2 wait cycles
    run_instr(6'b001000, 6'b000000, 0, 1'b0, 1'b1);   // addi with overflow
    run_instr(6'b001000, 6'b000000, 0, 1'b0, 1'b0);   // addi without overflow

    // Reset asserted while sw waits on data memory
    cyc(r6(), r6(), 1'b0, 1'b0, 1'b0);
    chk("rstmw_fetch", 32'(obs_strb()), 32'(ev(0, 0, 1, 0, 0, 0, 0, 0)));
    cyc(6'b101011, r6(), 1'b0, 1'b0, 1'b0);
    chk("rstmw_decode", 32'(obs_strb()), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0)));
    cyc(r6(), r6(), 1'b0, 1'b0, 1'b0);
    chk("rstmw_exec", 32'(obs_strb()), 32'(ev(2, 0, 0, 0, 0, 0, 0, 0)));
    cyc(r6(), r6(), 1'b0, 1'b0, 1'b0);
    chk("rstmw_wait", 32'(obs_strb()), 32'(ev(4, 0, 0, 0, 1, 0, 0, 0)));
    rst = 1'b1;
    #1;
    chk("rstmw_async", 32'({obs_strb(), obs_sel()}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_instr(6'b000000, 6'b100001, 0, 1'b0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 10);
      if (sel == 10) begin
        op = r6(); fn = r6();
      end else begin
        op = op_tab[sel];
        fn = (op == 6'b000000) ? fn_tab[sel] : r6();
      end
      run_instr(op, fn, $urandom_range(0, 3), rb(), rb());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
